// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register: operation modes,
// the two-state burst controller, and the burst-mode classifier.
package usr_pkg;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHL  = 3'b001;
   localparam logic [2:0] MODE_SHR  = 3'b010;
   localparam logic [2:0] MODE_ROL  = 3'b011;
   localparam logic [2:0] MODE_ROR  = 3'b100;
   localparam logic [2:0] MODE_LOAD = 3'b101;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   // Only shifts and rotates can be repeated as a burst.
   function automatic logic is_burst_mode(input logic [2:0] m);
      return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) || (m == MODE_ROR);
   endfunction

endpackage

// File: rtl/usr_next_q.sv
// Combinational next-value datapath, shared by single steps and burst steps.
// Codes 110/111 fall through to hold.
module usr_next_q
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  logic [2:0]       mode,
   input  logic             si_l,
   input  logic             si_r,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q_next
);

   always_comb begin
      q_next = q;
      case (mode)
         MODE_SHL:  q_next = {q[WIDTH-2:0], si_l};
         MODE_SHR:  q_next = {si_r, q[WIDTH-1:1]};
         MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
         MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
         MODE_LOAD: q_next = d;
         default:   q_next = q;
      endcase
   end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register with single-step operation and counted bursts.
// A burst latches its mode and count, then steps once per cycle until done.
module universal_shift_register
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             SI_L,
   input  logic             SI_R,
   input  logic [WIDTH-1:0] D,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] Q,
   output logic             SO_L,
   output logic             SO_R,
   output logic             busy,
   output logic             done
);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         mode_q, mode_d;
   logic               done_q, done_d;
   logic [2:0]         op_mode;
   logic [WIDTH-1:0]   step_q;

   // While bursting the latched mode drives the datapath; live mode is ignored.
   assign op_mode = (state_q == ST_BUSY) ? mode_q : mode;

   usr_next_q #(.WIDTH(WIDTH)) u_next_q (
      .q      (q_q),
      .mode   (op_mode),
      .si_l   (SI_L),
      .si_r   (SI_R),
      .d      (D),
      .q_next (step_q)
   );

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && is_burst_mode(mode)) begin
               if (count == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_BUSY;
                  cnt_d   = count;
                  mode_d  = mode;
               end
            end else if (en) begin
               q_d = step_q;
            end
         end
         ST_BUSY: begin
            q_d   = step_q;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         q_q     <= '0;
         cnt_q   <= '0;
         mode_q  <= MODE_HOLD;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
      end
   end

   assign Q    = q_q;
   assign SO_L = q_q[WIDTH-1];
   assign SO_R = q_q[0];
   assign busy = (state_q == ST_BUSY);
   assign done = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench driving a 4-bit and an 8-bit instance with identical stimulus, checked
// against hand-derived vectors and an arithmetic reference model.
module tb_universal_shift_register;

   logic       clk = 1'b0;
   logic       rst_n, en, si_l, si_r, start;
   logic [2:0] mode;
   logic [7:0] d_in;
   logic [3:0] count;

   logic [3:0] q4;
   logic       so_l4, so_r4, busy4, done4;
   logic [7:0] q8;
   logic       so_l8, so_r8, busy8, done8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   universal_shift_register #(.WIDTH(4), .CNT_W(4)) u4 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .SI_L(si_l), .SI_R(si_r),
      .D(d_in[3:0]), .start(start), .count(count),
      .Q(q4), .SO_L(so_l4), .SO_R(so_r4), .busy(busy4), .done(done4)
   );

   universal_shift_register #(.WIDTH(8), .CNT_W(4)) u8 (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .SI_L(si_l), .SI_R(si_r),
      .D(d_in), .start(start), .count(count),
      .Q(q8), .SO_L(so_l8), .SO_R(so_r8), .busy(busy8), .done(done8)
   );

   // Reference model: register value as a number, burst as "steps remaining".
   logic [63:0] m_q[2];
   int          m_rem[2];
   bit          m_busy[2];
   bit          m_done[2];
   logic [2:0]  m_mode[2];
   int          m_w[2] = '{4, 8};

   function automatic logic [63:0] apply_op(input logic [2:0] md, input logic [63:0] q,
                                            input int w, input logic sl, input logic sr,
                                            input logic [63:0] dd);
      logic [63:0] mask;
      mask = (64'd1 << w) - 64'd1;
      case (md)
         3'd1:    return ((q << 1) | 64'(sl)) & mask;
         3'd2:    return (q >> 1) | (64'(sr) << (w - 1));
         3'd3:    return ((q << 1) | (q >> (w - 1))) & mask;
         3'd4:    return (q >> 1) | ((q & 64'd1) << (w - 1));
         3'd5:    return dd & mask;
         default: return q;
      endcase
   endfunction

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_q[i] = '0; m_rem[i] = 0; m_busy[i] = 0; m_done[i] = 0;
         end else if (m_busy[i]) begin
            m_q[i]   = apply_op(m_mode[i], m_q[i], m_w[i], si_l, si_r, 64'(d_in));
            m_rem[i] = m_rem[i] - 1;
            m_done[i] = (m_rem[i] == 0);
            if (m_rem[i] == 0) m_busy[i] = 0;
         end else begin
            m_done[i] = 0;
            if (start && mode >= 3'd1 && mode <= 3'd4) begin
               if (count == 4'd0) m_done[i] = 1;
               else begin
                  m_busy[i] = 1; m_rem[i] = int'(count); m_mode[i] = mode;
               end
            end else if (en) begin
               m_q[i] = apply_op(mode, m_q[i], m_w[i], si_l, si_r, 64'(d_in));
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: advance the model with the inputs present at the edge, then compare.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      $display("t=%0t rst_n=%b en=%b mode=%0d sl=%b sr=%b d=%h start=%b cnt=%0d | q4=%h q8=%h busy=%b%b done=%b%b",
               $time, rst_n, en, mode, si_l, si_r, d_in, start, count, q4, q8, busy4, busy8, done4, done8);
      chk("model.u4.Q", 64'(q4), m_q[0]);
      chk("model.u4.flags", 64'({busy4, done4, so_l4, so_r4}),
          64'({m_busy[0], m_done[0], m_q[0][3], m_q[0][0]}));
      chk("model.u8.Q", 64'(q8), m_q[1]);
      chk("model.u8.flags", 64'({busy8, done8, so_l8, so_r8}),
          64'({m_busy[1], m_done[1], m_q[1][7], m_q[1][0]}));
   endtask

   typedef struct packed {
      logic       rst_n;
      logic       en;
      logic [2:0] mode;
      logic       si_l;
      logic       si_r;
      logic [7:0] d;
      logic       start;
      logic [3:0] count;
      logic [3:0] exp_q;
      logic       exp_busy;
      logic       exp_done;
   } vec_t;

   vec_t tbl[23];

   initial begin
      int busy_cnt;
      int done_cnt;

      rst_n = 0; en = 0; mode = 0; si_l = 0; si_r = 0; d_in = 0; start = 0; count = 0;

      // Expected values below are for the 4-bit instance.
      tbl[0]  = '{1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 8'hFF, 1'b1, 4'd3, 4'b0000, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 8'hA5, 1'b1, 4'd9, 4'b0000, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 4'b0001, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 4'b0010, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 4'b0101, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 4'b1011, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 4'b1011, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 8'h09, 1'b0, 4'd0, 4'b1001, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 8'h00, 1'b1, 4'd3, 4'b1001, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 4'b1100, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 8'h00, 1'b1, 4'd7, 4'b0110, 1'b1, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 8'hFF, 1'b1, 4'd2, 4'b0011, 1'b0, 1'b1};
      tbl[12] = '{1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 8'h00, 1'b1, 4'd2, 4'b0011, 1'b1, 1'b0};
      tbl[13] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 4'b0110, 1'b1, 1'b0};
      tbl[14] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 4'b1100, 1'b0, 1'b1};
      tbl[15] = '{1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 8'h00, 1'b1, 4'd0, 4'b1100, 1'b0, 1'b1};
      tbl[16] = '{1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 8'h00, 1'b0, 4'd0, 4'b1100, 1'b0, 1'b0};
      tbl[17] = '{1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 8'h05, 1'b1, 4'd3, 4'b0101, 1'b0, 1'b0};
      tbl[18] = '{1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 8'h0F, 1'b1, 4'd3, 4'b0101, 1'b0, 1'b0};
      tbl[19] = '{1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 8'h00, 1'b1, 4'd5, 4'b0101, 1'b1, 1'b0};
      tbl[20] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 8'h00, 1'b0, 4'd0, 4'b1010, 1'b1, 1'b0};
      tbl[21] = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 8'h00, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0};
      tbl[22] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0};

      for (int i = 0; i < 23; i++) begin
         rst_n = tbl[i].rst_n; en = tbl[i].en; mode = tbl[i].mode;
         si_l = tbl[i].si_l; si_r = tbl[i].si_r; d_in = tbl[i].d;
         start = tbl[i].start; count = tbl[i].count;
         tick();
         chk($sformatf("vec%0d.Q", i), 64'(q4), 64'(tbl[i].exp_q));
         chk($sformatf("vec%0d.busy", i), 64'(busy4), 64'(tbl[i].exp_busy));
         chk($sformatf("vec%0d.done", i), 64'(done4), 64'(tbl[i].exp_done));
      end

      // Long right-shift burst flushes all ones out with SI_R=0.
      rst_n = 1; en = 1; mode = 3'd5; d_in = 8'hFF; start = 0; count = 0; si_l = 0; si_r = 0;
      tick();
      chk("flush.load", 64'(q8), 64'hFF);
      en = 0; mode = 3'd2; start = 1; count = 4'd10;
      busy_cnt = 0; done_cnt = 0;
      tick();
      if (busy8) busy_cnt++;
      start = 0; mode = 3'd0; en = 1;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (busy8) busy_cnt++;
         if (done8) begin
            done_cnt++;
            chk("flush.q_at_done", 64'(q8), 64'h00);
         end
      end
      chk("flush.busy_cycles", 64'(busy_cnt), 64'd10);
      chk("flush.done_pulses", 64'(done_cnt), 64'd1);

      // Rotate count beyond width wraps: 5 left-rotates of 1.
      en = 1; mode = 3'd5; d_in = 8'h01; start = 0;
      tick();
      en = 0; mode = 3'd3; start = 1; count = 4'd5;
      tick();
      start = 0; mode = 3'd0;
      for (int k = 0; k < 6; k++) tick();
      chk("wrap.q4", 64'(q4), 64'h2);
      chk("wrap.q8", 64'(q8), 64'h20);

      // Randomized traffic against the model.
      for (int k = 0; k < 400; k++) begin
         rst_n = ($urandom_range(0, 49) != 0);
         en    = 1'($urandom_range(0, 1));
         mode  = 3'($urandom_range(0, 7));
         si_l  = 1'($urandom_range(0, 1));
         si_r  = 1'($urandom_range(0, 1));
         d_in  = 8'($urandom_range(0, 255));
         start = ($urandom_range(0, 3) == 0);
         count = 4'($urandom_range(0, 15));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: register width, legal range 2 to 64.
REQ-002 The block SHALL have parameter CNT_W, default 4: width of the burst count.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port en, input, 1 bit: single-step enable, used in IDLE only.
REQ-006 The block SHALL have port mode, input, 3 bits: operation select.
REQ-007 The block SHALL have port SI_L, input, 1 bit: serial input entering Q[0] on a left shift.
REQ-008 The block SHALL have port SI_R, input, 1 bit: serial input entering Q[WIDTH-1] on a right shift.
REQ-009 The block SHALL have port D, input, WIDTH bits: parallel load data.
REQ-010 The block SHALL have port start, input, 1 bit: burst request, sampled in IDLE only.
REQ-011 The block SHALL have port count, input, CNT_W bits: number of burst steps.
REQ-012 The block SHALL have port Q, output, WIDTH bits: register contents.
REQ-013 The block SHALL have port SO_L, output, 1 bit: combinational copy of Q[WIDTH-1].
REQ-014 The block SHALL have port SO_R, output, 1 bit: combinational copy of Q[0].
REQ-015 The block SHALL have port busy, output, 1 bit: high while a burst is in progress.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle pulse when a burst completes.

Function
REQ-017 The mode encoding SHALL be:
- 000 HOLD.
- 001 SHL: Q <= {Q[W-2:0], SI_L}.
- 010 SHR: Q <= {SI_R, Q[W-1:1]}.
- 011 ROL: Q <= {Q[W-2:0], Q[W-1]}.
- 100 ROR: Q <= {Q[0], Q[W-1:1]}.
- 101 LOAD: Q <= D.
- 110 and 111: HOLD.
REQ-018 The FSM SHALL have exactly two states, IDLE and BUSY, and reset into IDLE.
REQ-019 In IDLE with start=0 and en=1, the block SHALL apply the mode operation once at the next edge; with en=0, Q SHALL hold.
REQ-020 In IDLE with start=1, mode in {SHL, SHR, ROL, ROR} and count>0, the block SHALL:
- latch mode and count;
- enter BUSY;
- ignore en that cycle.
REQ-021 In BUSY, the block SHALL perform one latched-mode step per cycle using live SI_L/SI_R and decrement the remaining count, without requiring en.
REQ-022 In BUSY, the block SHALL ignore mode, en, start, D and count.
REQ-023 A burst of N steps SHALL change Q on exactly N consecutive edges, with busy high for exactly N cycles, starting the cycle after start is sampled.
REQ-024 On the edge of the final step, the block SHALL return to IDLE and set done=1 for exactly one cycle, registered together with the final Q value.
REQ-025 start=1 with count=0 and a shift/rotate mode SHALL leave Q unchanged, keep busy=0 and pulse done for one cycle.
REQ-026 start=1 with a non-shift mode (HOLD, LOAD, 110, 111) SHALL be treated as start=0, i.e. single-step rules apply.
REQ-027 count values greater than WIDTH SHALL be legal; rotates wrap modulo WIDTH, and shifts fully flush to serial-input data.
REQ-028 start asserted on the same edge as the done pulse SHALL be accepted, since the block is IDLE then, giving back-to-back bursts with busy low for exactly one cycle between them.

Reset
REQ-029 When rst_n=0 at a rising clk edge, the block SHALL set:
- Q = 0;
- busy = 0;
- done = 0;
- remaining count = 0;
- state = IDLE.
REQ-030 Reset SHALL override all other inputs, including during BUSY; an aborted burst SHALL NOT produce a done pulse.
REQ-031 SO_L and SO_R SHALL follow the reset Q value (0), since they are combinational from Q.

Structure
REQ-032 A shared package usr_pkg SHALL hold the mode encodings (MODE_HOLD ... MODE_LOAD) and the state encodings (ST_IDLE, ST_BUSY).
REQ-033 A single combinational sub-module usr_next_q SHALL compute the next Q from (Q, mode, SI_L, SI_R, D) and be used by both the single-step and burst paths.
REQ-034 The design SHALL NOT contain latches, and SHALL NOT use a second clock or asynchronous reset.

Verification
REQ-035 Reset, WIDTH=4: hold rst_n=0 for 2 edges with random inputs -> Q=0000, busy=0, done=0.
REQ-036 SHL single-step, WIDTH=4: en=1, mode=001, SI_L = 1,0,1,1 on successive edges -> Q = 0001, 0010, 0101, 1011.
REQ-037 Rotate burst, WIDTH=4:
- LOAD D=1001;
- then start, mode=100, count=3;
- -> Q = 1100, 0110, 0011;
- busy high for 3 cycles;
- done pulses with Q=0011.
REQ-038 SHR burst, WIDTH=8: Q=0xFF, start, mode=010, SI_R=0, count=10 -> Q=0x00 after 10 cycles, busy high for 10 cycles, one done pulse.
REQ-039 Reset mid-burst: assert rst_n=0 at the 2nd BUSY cycle -> Q=0, state IDLE, no done pulse.
REQ-040 Edge cases:
- count=0 with start -> done pulse, Q unchanged, busy=0;
- start on the done cycle -> second burst accepted.
